// File: rtl/add_and_subtract_unit_pkg.sv
// Shared constants for the EX-stage arithmetic blocks.
//   XLEN : default datapath width, shared by the ALU and the add/subtract unit.
package add_and_subtract_unit_pkg;

   localparam int XLEN = 32;

endpackage : add_and_subtract_unit_pkg

// File: rtl/add_and_subtract_unit_full_adder.sv
// One-bit full adder, the cell of the ripple-carry chain.
// Ports:
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);

   logic p;

   assign p  = x ^ y;
   assign s  = p ^ cin;
   assign co = (x & y) | (cin & p);

endmodule : full_adder

// File: rtl/add_and_subtract_unit.sv
// Registered two's-complement adder/subtractor with carry-out.
// subtract=0 gives a + b; subtract=1 gives a + ~b + 1 = a - b.
// On subtract, cout is the inverted borrow (1 when a >= b unsigned).
// Results appear one cycle after the operands are sampled.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears sum/cout
//   a        : first operand (minuend on subtract)
//   b        : second operand (subtrahend on subtract)
//   subtract : 0 add, 1 subtract
//   sum      : registered low WIDTH bits of the result
//   cout     : registered carry out of bit WIDTH-1
module add_and_subtract_unit
   import add_and_subtract_unit_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             subtract,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] s_next;

   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;

   // Inverting b and injecting subtract as carry-in forms the two's complement.
   assign b_eff    = b ^ {WIDTH{subtract}};
   assign carry[0] = subtract;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rca
      full_adder u_fa (
         .x   (a[i]),
         .y   (b_eff[i]),
         .cin (carry[i]),
         .s   (s_next[i]),
         .co  (carry[i+1])
      );
   end

   always_comb begin
      sum_d  = s_next;
      cout_d = carry[WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : add_and_subtract_unit

// File: tb/tb_add_and_subtract_unit.sv
module tb_add_and_subtract_unit;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic        subtract;
   logic [31:0] sum;
   logic        cout;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run;
   int   tests_failed;

   add_and_subtract_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a),
      .b        (b),
      .subtract (subtract),
      .sum      (sum),
      .cout     (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; the expected result is queued for the
   // following rising edge.
   task automatic drive(input logic r, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [31:0] es, input logic ec,
                        input string nm);
      exp_t e;
      @(negedge clk);
      reset    = r;
      a        = av;
      b        = bv;
      subtract = sv;
      e.sum  = es;
      e.cout = ec;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: every rising edge produces one result, compared 1 time unit later.
   initial begin
      exp_t e;
      tests_run    = 0;
      tests_failed = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (sum !== e.sum || cout !== e.cout) begin
               tests_failed++;
               $display("FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
                        e.name, sum, cout, e.sum, e.cout);
            end
         end
      end
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      logic [31:0] es;
      logic        ec;
      int          drain;

      reset    = 1'b1;
      a        = 32'd5;
      b        = 32'd3;
      subtract = 1'b0;

      drive(1'b1, 32'd5, 32'd3, 1'b0, 32'd0, 1'b0, "reset_hold0");
      drive(1'b1, 32'd5, 32'd3, 1'b0, 32'd0, 1'b0, "reset_hold1");
      drive(1'b0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, "reset_release_add");

      drive(1'b0, 32'd5, 32'd3, 1'b0, 32'h0000_0008, 1'b0, "add_basic");
      drive(1'b0, 32'd5, 32'd3, 1'b1, 32'h0000_0002, 1'b1, "sub_no_borrow");
      drive(1'b0, 32'd7, 32'd7, 1'b1, 32'h0000_0000, 1'b1, "sub_equal");
      drive(1'b0, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
      drive(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, "add_wrap");
      drive(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, "add_bias");
      drive(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, "add_signed_ovf");
      drive(1'b0, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, "sub_zero_minus_one");
      drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, "add_max_max");
      drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0000, 1'b1, "sub_zero_zero");
      drive(1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, "sub_min_minus_one");
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'd0, 1'b0, "reset_mid_directed");
      drive(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, "after_reset_add");

      // Back-to-back random traffic with a reset pulse in the middle.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom();
         rb = $urandom();
         rs = 1'($urandom_range(0, 1));
         if (i == 500 || i == 501) begin
            drive(1'b1, ra, rb, rs, 32'd0, 1'b0, "rand_reset");
         end else begin
            if (rs) begin
               es = ra - rb;
               ec = (ra >= rb);
            end else begin
               es = ra + rb;
               ec = ({1'b0, ra} + {1'b0, rb}) > 33'h0_FFFF_FFFF;
            end
            drive(1'b0, ra, rb, rs, es, ec, "rand");
         end
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      if (exp_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_add_and_subtract_unit
